// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU operation arbiter.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

    localparam int DEFAULT_PRECISION = 32;

    // Result returned when the FU never answers; sliced to PRECISION by users.
    localparam logic [63:0] INVALID_RESULT = '1;

endpackage

// File: rtl/fpu_op_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap so non-power-of-two N works.
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Round-robin sharing of one start/done FU among NUM_REQ requesters.
// Optional watchdog in WAIT enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_op_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int PRECISION      = DEFAULT_PRECISION,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PRECISION-1:0]   req_a,
    input  logic [NUM_REQ*PRECISION-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [PRECISION-1:0]           rsp_result,
    output logic                           rsp_invalid,
    output logic                           fu_start,
    output logic [PRECISION-1:0]           fu_a,
    output logic [PRECISION-1:0]           fu_b,
    input  logic [PRECISION-1:0]           fu_result,
    input  logic                           fu_invalid_op,
    input  logic                           fu_done,
    output logic                           busy
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [PRECISION-1:0]   fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    logic [PRECISION-1:0]   rsp_result_q, rsp_result_d;
    logic                   rsp_invalid_q, rsp_invalid_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   tmo_expired;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmo_q, tmo_d;

    // Loaded while leaving ISSUE so the first WAIT cycle sees TIMEOUT_CYCLES-1.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ISSUE)
            tmo_d = CW'(TIMEOUT_CYCLES - 1);
        else if (state_q == WAIT && tmo_q != '0)
            tmo_d = tmo_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_expired = (state_q == WAIT) && (tmo_q == '0);
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        fu_a_d        = fu_a_q;
        fu_b_d        = fu_b_q;
        rsp_result_d  = rsp_result_q;
        rsp_invalid_d = rsp_invalid_q;
        rsp_valid_d   = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    fu_a_d  = req_a[int'(arb_idx)*PRECISION +: PRECISION];
                    fu_b_d  = req_b[int'(arb_idx)*PRECISION +: PRECISION];
                    grant_d = arb_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // fu_done wins over a simultaneous watchdog expiry.
                if (fu_done) begin
                    rsp_result_d  = fu_result;
                    rsp_invalid_d = fu_invalid_op;
                    rsp_valid_d   = NUM_REQ'(1) << grant_q;
                    state_d       = RESPOND;
                end else if (tmo_expired) begin
                    rsp_result_d  = INVALID_RESULT[PRECISION-1:0];
                    rsp_invalid_d = 1'b1;
                    rsp_valid_d   = NUM_REQ'(1) << grant_q;
                    state_d       = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            fu_a_q        <= '0;
            fu_b_q        <= '0;
            rsp_result_q  <= '0;
            rsp_invalid_q <= 1'b0;
            rsp_valid_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            fu_a_q        <= fu_a_d;
            fu_b_q        <= fu_b_d;
            rsp_result_q  <= rsp_result_d;
            rsp_invalid_q <= rsp_invalid_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign req_ready   = (state_q == IDLE) ? arb_grant : '0;
    assign fu_start    = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign fu_a        = fu_a_q;
    assign fu_b        = fu_b_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_invalid = rsp_invalid_q;
    assign rsp_valid   = rsp_valid_q;

endmodule
